// File: rtl/sub_serial8_pkg.sv
// Shared FSM encoding and default width for the bit-serial subtractor.
package sub_serial8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SUB_W = 8;

endpackage

// File: rtl/sub_serial8_sub1.sv
// 1-bit full subtractor: d = a - b - bin, combinational, no handshake.
module sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial8.sv
// Bit-serial a - b - bin, LSB first through one sub1 cell; WIDTH run cycles then a done pulse.
// start is honoured only in IDLE; requests while busy or done are dropped, not queued.
import sub_serial8_pkg::*;

module sub_serial8 #(
  parameter int WIDTH = SUB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;

  sub1 u_sub1 (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d),
    .bout (bo)
  );

  // res only keeps the first WIDTH-1 result bits; the MSB goes straight into diff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= (res >> 1) | ((WIDTH-1)'(d) << (WIDTH - 2));
          br   <= bo;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= {d, res};
            bout  <= bo;
            // br here is the borrow into the MSB, bo the borrow out of it.
            ovf   <= br ^ bo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial8.sv
// Scoreboard bench for sub_serial8: timing model plus arithmetic reference feed a result queue.
module tb_sub_serial8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  sub_serial8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   cyc     = 0;
  int   free    = 0;
  int   acc_k   = -1000;
  int   done_at = -1;
  int   rd      = 0;
  int   total   = 0;
  int   passed  = 0;
  res_t hold    = '0;
  logic fin     = 1'b0;
  logic exp_busy;
  logic exp_done;

  function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    res_t r;
    int ux, uy, sx, sy, ud, sd;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ud = ux - uy - int'(bi);
    sd = sx - sy - int'(bi);
    r.diff = ud[W-1:0];
    r.bout = (ux < uy + int'(bi));
    r.ovf  = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // Timing model: an accepted start at edge k owns the unit until edge k+W+2.
  always @(posedge clk or posedge rst) begin
    if (clk) cyc++;
    if (rst) begin
      free    = 0;
      acc_k   = -1000;
      done_at = -1;
    end else if (start && cyc >= free) begin
      acc_k   = cyc;
      done_at = cyc + W;
      free    = cyc + W + 2;
      exp_q.push_back(ref_sub(a, b, bin));
    end
  end

  initial begin
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (fin) break;
      if (rst) begin
        rd   = exp_q.size();
        hold = '0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
      end else begin
        exp_busy = (cyc >= acc_k) && (cyc < acc_k + W);
        exp_done = (cyc == done_at);
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        if (done) begin
          if (rd < exp_q.size()) begin
            hold = exp_q[rd];
            rd++;
          end else begin
            check("unexpected done", 32'd1, 32'd0);
          end
        end
      end
      check("diff/bout/ovf", 32'({diff, bout, ovf}), 32'(hold));
    end
    check("results drained", 32'(rd), 32'(exp_q.size()));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    @(negedge clk);
    a = x; b = y; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
    repeat (W + 2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    op(8'h50, 8'h20, 1'b0);
    op(8'h00, 8'h01, 1'b0);
    op(8'h05, 8'h05, 1'b1);
    op(8'h80, 8'h01, 1'b0);
    op(8'h7F, 8'hFF, 1'b0);

    // A second request mid-run must be dropped.
    @(negedge clk);
    a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // start held high: back-to-back runs with operands changing every cycle.
    start = 1'b1;
    repeat (45) begin
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Asynchronous reset in the middle of a run discards it.
    a = 8'h99; b = 8'h33; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    op(8'h10, 8'h01, 1'b0);

    repeat (400) begin
      @(negedge clk);
      start = ($urandom % 4 == 0);
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    fin = 1'b1;
  end

endmodule
